// File: rtl/reg_file_param_pkg.sv
// Shared datapath sizing for the register file and the modules around it.
package reg_file_param_pkg;

  localparam int unsigned DefDataWidth = 32;
  localparam int unsigned DefAddrWidth = 5;

endpackage

// File: rtl/reg_file_param_reg_n.sv
// Word-wide register with load enable and synchronous active-high clear.
module reg_file_param_reg_n #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] data_d, data_q;

  always_comb begin
    data_d = data_q;
    if (en_i) data_d = d_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) data_q <= '0;
    else       data_q <= data_d;
  end

  assign q_o = data_q;

endmodule

// File: rtl/reg_file_param.sv
// Parametrised register file: one synchronous write port, two registered read ports,
// optional hardwired-zero word 0 and optional write-to-read forwarding.
module reg_file_param
  import reg_file_param_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned ADDR_WIDTH = DefAddrWidth,
  parameter bit          ZERO_REG   = 1'b1,
  parameter bit          BYPASS     = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  WE,
  input  logic [ADDR_WIDTH-1:0] WADDR,
  input  logic [DATA_WIDTH-1:0] WDATA,
  input  logic                  RE,
  input  logic [ADDR_WIDTH-1:0] RADDR1,
  input  logic [ADDR_WIDTH-1:0] RADDR2,
  output logic [DATA_WIDTH-1:0] RDATA1,
  output logic [DATA_WIDTH-1:0] RDATA2
);

  localparam int unsigned Depth = 1 << ADDR_WIDTH;

  logic [Depth-1:0]      wr_sel;
  logic [DATA_WIDTH-1:0] word_q [Depth];
  logic [DATA_WIDTH-1:0] rd1_d, rd2_d;

  // One-hot write decode; word 0 never loads when it is hardwired to zero.
  always_comb begin
    wr_sel = '0;
    if (WE) wr_sel[WADDR] = 1'b1;
    if (ZERO_REG) wr_sel[0] = 1'b0;
  end

  for (genvar i = 0; i < Depth; i++) begin : g_word
    reg_file_param_reg_n #(
      .Width (DATA_WIDTH)
    ) u_word (
      .clk_i (CLK),
      .rst_i (RST),
      .en_i  (wr_sel[i]),
      .d_i   (WDATA),
      .q_o   (word_q[i])
    );
  end

  // Forwarding feeds the output register, so WDATA never reaches RDATAn combinationally.
  always_comb begin
    rd1_d = word_q[RADDR1];
    rd2_d = word_q[RADDR2];
    if (BYPASS && WE && (WADDR == RADDR1)) rd1_d = WDATA;
    if (BYPASS && WE && (WADDR == RADDR2)) rd2_d = WDATA;
    if (ZERO_REG && (RADDR1 == '0)) rd1_d = '0;
    if (ZERO_REG && (RADDR2 == '0)) rd2_d = '0;
  end

  reg_file_param_reg_n #(
    .Width (DATA_WIDTH)
  ) u_rd1 (
    .clk_i (CLK),
    .rst_i (RST),
    .en_i  (RE),
    .d_i   (rd1_d),
    .q_o   (RDATA1)
  );

  reg_file_param_reg_n #(
    .Width (DATA_WIDTH)
  ) u_rd2 (
    .clk_i (CLK),
    .rst_i (RST),
    .en_i  (RE),
    .d_i   (rd2_d),
    .q_o   (RDATA2)
  );

endmodule

// File: tb/tb_reg_file_param.sv
// Bench for reg_file_param: three configurations against an array-based reference model.
module tb_reg_file_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // 32x32 instances: a = zero reg + bypass, b = neither
  logic        rst, we, re;
  logic [4:0]  waddr, ra1, ra2;
  logic [31:0] wdata;
  logic [31:0] rd1_a, rd2_a, rd1_b, rd2_b;
  // 8x8 instance, zero reg + bypass
  logic        rst8, we8, re8;
  logic [2:0]  wa8, r81, r82;
  logic [7:0]  wd8, rd81, rd82;

  reg_file_param #(
    .DATA_WIDTH (32), .ADDR_WIDTH (5), .ZERO_REG (1'b1), .BYPASS (1'b1)
  ) u_dut_a (
    .CLK (clk), .RST (rst), .WE (we), .WADDR (waddr), .WDATA (wdata), .RE (re),
    .RADDR1 (ra1), .RADDR2 (ra2), .RDATA1 (rd1_a), .RDATA2 (rd2_a)
  );

  reg_file_param #(
    .DATA_WIDTH (32), .ADDR_WIDTH (5), .ZERO_REG (1'b0), .BYPASS (1'b0)
  ) u_dut_b (
    .CLK (clk), .RST (rst), .WE (we), .WADDR (waddr), .WDATA (wdata), .RE (re),
    .RADDR1 (ra1), .RADDR2 (ra2), .RDATA1 (rd1_b), .RDATA2 (rd2_b)
  );

  reg_file_param #(
    .DATA_WIDTH (8), .ADDR_WIDTH (3), .ZERO_REG (1'b1), .BYPASS (1'b1)
  ) u_dut_8 (
    .CLK (clk), .RST (rst8), .WE (we8), .WADDR (wa8), .WDATA (wd8), .RE (re8),
    .RADDR1 (r81), .RADDR2 (r82), .RDATA1 (rd81), .RDATA2 (rd82)
  );

  // Reference state
  logic [31:0] ma [32];
  logic [31:0] mb [32];
  logic [7:0]  m8 [8];
  logic [31:0] e1a, e2a, e1b, e2b;
  logic [7:0]  e81, e82;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // What a read returns given the rules, the pre-edge word value and the concurrent write.
  function automatic logic [31:0] model_read(input bit zr, input bit bp, input logic [31:0] stored,
                                             input int ra, input bit w, input int wa,
                                             input logic [31:0] wd);
    if (zr && ra == 0) return 32'h0;
    if (bp && w && wa == ra) return wd;
    return stored;
  endfunction

  task automatic tick(input bit r, input bit w, input int wa, input logic [31:0] wd,
                      input bit rd, input int a1, input int a2);
    rst = r; we = w; waddr = 5'(wa); wdata = wd; re = rd; ra1 = 5'(a1); ra2 = 5'(a2);
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 32; i++) begin ma[i] = '0; mb[i] = '0; end
      e1a = '0; e2a = '0; e1b = '0; e2b = '0;
    end else begin
      if (rd) begin
        e1a = model_read(1'b1, 1'b1, ma[a1], a1, w, wa, wd);
        e2a = model_read(1'b1, 1'b1, ma[a2], a2, w, wa, wd);
        e1b = model_read(1'b0, 1'b0, mb[a1], a1, w, wa, wd);
        e2b = model_read(1'b0, 1'b0, mb[a2], a2, w, wa, wd);
      end
      if (w && wa != 0) ma[wa] = wd;
      if (w) mb[wa] = wd;
    end
    #1;
    check_val("a_rdata1", rd1_a, e1a);
    check_val("a_rdata2", rd2_a, e2a);
    check_val("b_rdata1", rd1_b, e1b);
    check_val("b_rdata2", rd2_b, e2b);
  endtask

  task automatic tick8(input bit r, input bit w, input int wa, input logic [7:0] wd,
                       input bit rd, input int a1, input int a2);
    rst8 = r; we8 = w; wa8 = 3'(wa); wd8 = wd; re8 = rd; r81 = 3'(a1); r82 = 3'(a2);
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 8; i++) m8[i] = '0;
      e81 = '0; e82 = '0;
    end else begin
      if (rd) begin
        e81 = 8'(model_read(1'b1, 1'b1, 32'(m8[a1]), a1, w, wa, 32'(wd)));
        e82 = 8'(model_read(1'b1, 1'b1, 32'(m8[a2]), a2, w, wa, 32'(wd)));
      end
      if (w && wa != 0) m8[wa] = wd;
    end
    #1;
    check_val("p8_rdata1", 32'(rd81), 32'(e81));
    check_val("p8_rdata2", 32'(rd82), 32'(e82));
  endtask

  initial begin
    rst8 = 1'b1; we8 = 1'b0; re8 = 1'b0; wa8 = '0; wd8 = '0; r81 = '0; r82 = '0;

    // Reset wipes a prior write
    tick(1, 0, 0, 0, 0, 0, 0);
    tick(0, 1, 5, 32'h02468ace, 0, 0, 0);
    tick(1, 1, 9, 32'h55555555, 1, 5, 9);
    check_val("rst_rdata1", rd1_a, 32'h0);
    check_val("rst_rdata2", rd2_a, 32'h0);
    tick(0, 0, 0, 0, 1, 5, 9);
    check_val("rst_read5", rd1_a, 32'h0);
    check_val("rst_read9", rd2_b, 32'h0);

    // Write then read on both ports, then hold
    tick(0, 1, 21, 32'h13579bdf, 0, 0, 0);
    tick(0, 0, 0, 0, 1, 21, 21);
    check_val("rd21_p1", rd1_a, 32'h13579bdf);
    check_val("rd21_p2", rd2_a, 32'h13579bdf);
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 0, 0, 0, 3, 3);
      check_val("hold_p1", rd1_a, 32'h13579bdf);
    end

    // Same-cycle write/read of word 7
    tick(0, 1, 7, 32'h11111111, 0, 0, 0);
    tick(0, 1, 7, 32'hdeadbeef, 1, 7, 21);
    check_val("bypass_on", rd1_a, 32'hdeadbeef);
    check_val("bypass_off", rd1_b, 32'h11111111);
    check_val("bypass_other", rd2_b, 32'h13579bdf);

    // Word 0 hardwired vs ordinary
    tick(0, 1, 0, 32'hffffffff, 0, 0, 0);
    tick(0, 0, 0, 0, 1, 0, 0);
    check_val("zero_reg_on", rd1_a, 32'h0);
    check_val("zero_reg_off", rd1_b, 32'hffffffff);
    tick(0, 1, 0, 32'hffffffff, 1, 0, 7);
    check_val("zero_bypass", rd1_a, 32'h0);
    check_val("zero_bypass_p2", rd2_a, 32'hdeadbeef);

    // Randomised traffic with address collisions encouraged
    for (int n = 0; n < 400; n++) begin
      int wa_r, a1_r, a2_r;
      wa_r = int'($urandom_range(0, 31));
      a1_r = ($urandom_range(0, 2) == 0) ? wa_r : int'($urandom_range(0, 31));
      a2_r = ($urandom_range(0, 3) == 0) ? a1_r : int'($urandom_range(0, 31));
      tick($urandom_range(0, 59) == 0, 1'($urandom), wa_r, $urandom,
           $urandom_range(0, 3) != 0, a1_r, a2_r);
    end

    // 8x8 sweep: word i holds i*8'h11
    tick8(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) tick8(0, 1, i, 8'(i * 17), 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      tick8(0, 0, 0, 0, 1, i, 7 - i);
      check_val("p8_word", 32'(rd81), (i == 0) ? 32'h0 : 32'(8'(i * 17)));
    end
    tick8(0, 0, 0, 0, 1, 7, 7);
    check_val("p8_word7", 32'(rd82), 32'h77);
    for (int n = 0; n < 200; n++) begin
      int wa_r, a1_r;
      wa_r = int'($urandom_range(0, 7));
      a1_r = ($urandom_range(0, 2) == 0) ? wa_r : int'($urandom_range(0, 7));
      tick8($urandom_range(0, 49) == 0, 1'($urandom), wa_r, 8'($urandom),
            $urandom_range(0, 3) != 0, a1_r, int'($urandom_range(0, 7)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
